// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: start, DBIT data bits LSB first, optional parity, stop.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [4:0] MidTick  = 5'(MID_TICK);
  localparam logic [4:0] BitLast  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] StopLast = 5'(SB_TICK - 1);
  localparam logic [2:0] NLast    = 3'(DBIT - 1);

  logic rx_s;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  uart_rx_state_t state_q, state_d;
  logic [4:0]     s_q, s_d;
  logic [2:0]     n_q, n_d;
  logic [7:0]     b_q, b_d;
  logic           done_q, done_d;
  logic           ferr_q, ferr_d;

`ifdef UART_RX_PARITY_EN
  localparam logic ParOdd = (PARITY_ODD != 0);
  logic p_q, p_d;
  logic pmis_q, pmis_d;
  logic perr_q, perr_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    p_d     = p_q;
    pmis_d  = pmis_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // Start-bit detection does not wait for a tick.
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == MidTick) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
`ifdef UART_RX_PARITY_EN
              p_d     = 1'b0;
`endif
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == BitLast) begin
            b_d = {rx_s, b_q[7:1]};
            s_d = '0;
`ifdef UART_RX_PARITY_EN
            p_d = p_q ^ rx_s;
`endif
            if (n_q == NLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == BitLast) begin
            pmis_d  = rx_s ^ p_q ^ ParOdd;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == StopLast) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = pmis_q;
`endif
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_q     <= 1'b0;
      pmis_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      p_q     <= p_d;
      pmis_q  <= pmis_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign dout         = b_q >> (8 - DBIT);
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clk, 64 clk per bit, DBIT=8, SB_TICK=16.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  logic [1:0] tick_cnt = 2'd0;
  always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
  assign s_tick = (tick_cnt == 2'd3);

  uart_rx #(
    .DBIT      (8),
    .SB_TICK   (16),
    .PARITY_ODD(0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  // Record every completed frame, sampled on the falling clock edge.
  logic [7:0] q_dout[$];
  logic       q_ferr[$];
  logic       q_perr[$];
  logic       q_busy[$];
  int         stray_err;
  logic       busy_seen;

  always @(negedge clk) begin
    if (rx_done_tick) begin
      q_dout.push_back(dout);
      q_ferr.push_back(frame_err);
      q_perr.push_back(parity_err);
      q_busy.push_back(busy);
    end
    if (!rx_done_tick && (frame_err || parity_err)) stray_err = stray_err + 1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic clear_mon();
    q_dout.delete();
    q_ferr.delete();
    q_perr.delete();
    q_busy.delete();
    stray_err = 0;
    busy_seen = 1'b0;
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk) rx = v;
    repeat (63) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    for (int i = 0; i < bits; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_v);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    tests_run++;
    if (dout !== 8'h00) begin
      tests_failed++; $display("FAIL reset_dout: got %h expected 00", dout);
    end
    tests_run++;
    if (rx_done_tick !== 1'b0) begin
      tests_failed++; $display("FAIL reset_done: got %b expected 0", rx_done_tick);
    end
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ferr: got %b expected 0", frame_err);
    end
    tests_run++;
    if (parity_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_perr: got %b expected 0", parity_err);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    @(negedge clk) reset = 1'b0;
    idle(2);
  endtask

  task automatic test_clean_frame();
    clear_mon();
    send_frame(8'hA5, 1'b1);
    idle(2);
    tests_run++;
    if (q_dout.size() !== 1) begin
      tests_failed++; $display("FAIL clean_count: got %0d expected 1", q_dout.size());
    end else begin
      tests_run++;
      if (q_dout[0] !== 8'hA5) begin
        tests_failed++; $display("FAIL clean_dout: got %h expected a5", q_dout[0]);
      end
      tests_run++;
      if (q_ferr[0] !== 1'b0) begin
        tests_failed++; $display("FAIL clean_ferr: got %b expected 0", q_ferr[0]);
      end
      tests_run++;
      if (q_perr[0] !== 1'b0) begin
        tests_failed++; $display("FAIL clean_perr: got %b expected 0", q_perr[0]);
      end
      tests_run++;
      if (q_busy[0] !== 1'b0) begin
        tests_failed++; $display("FAIL clean_busy_at_done: got %b expected 0", q_busy[0]);
      end
    end
    tests_run++;
    if (stray_err !== 0) begin
      tests_failed++; $display("FAIL clean_stray_err: got %0d expected 0", stray_err);
    end
    tests_run++;
    if (busy_seen !== 1'b1) begin
      tests_failed++; $display("FAIL clean_busy_seen: got %b expected 1", busy_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h3C;
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
    idle(2);
    tests_run++;
    if (q_dout.size() !== 3) begin
      tests_failed++; $display("FAIL b2b_count: got %0d expected 3", q_dout.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (q_dout[i] !== exp_b[i] || q_ferr[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_frame%0d: got %h ferr %b expected %h ferr 0",
                   i, q_dout[i], q_ferr[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_false_start();
    clear_mon();
    @(negedge clk) rx = 1'b0;
    repeat (24) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    tests_run++;
    if (q_dout.size() !== 0) begin
      tests_failed++; $display("FAIL false_count: got %0d expected 0", q_dout.size());
    end
    tests_run++;
    if (busy_seen !== 1'b1) begin
      tests_failed++; $display("FAIL false_busy_pulse: got %b expected 1", busy_seen);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL false_busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_bad_stop();
    int last;
    clear_mon();
    send_frame(8'h55, 1'b0);
    // A full-length low stop bit may be taken as a new start bit; let that settle.
    idle(12);
    send_frame(8'h12, 1'b1);
    idle(2);
    tests_run++;
    if (q_dout.size() < 2) begin
      tests_failed++; $display("FAIL badstop_count: got %0d expected >=2", q_dout.size());
    end else begin
      last = q_dout.size() - 1;
      tests_run++;
      if (q_dout[0] !== 8'h55) begin
        tests_failed++; $display("FAIL badstop_dout: got %h expected 55", q_dout[0]);
      end
      tests_run++;
      if (q_ferr[0] !== 1'b1) begin
        tests_failed++; $display("FAIL badstop_ferr: got %b expected 1", q_ferr[0]);
      end
      tests_run++;
      if (q_dout[last] !== 8'h12) begin
        tests_failed++; $display("FAIL resync_dout: got %h expected 12", q_dout[last]);
      end
      tests_run++;
      if (q_ferr[last] !== 1'b0) begin
        tests_failed++; $display("FAIL resync_ferr: got %b expected 0", q_ferr[last]);
      end
    end
    tests_run++;
    if (stray_err !== 0) begin
      tests_failed++; $display("FAIL badstop_stray_err: got %0d expected 0", stray_err);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    d = 8'h07;
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b0);
    drive_bit(1'b1);
    idle(2);
    tests_run++;
    if (q_dout.size() !== 2) begin
      tests_failed++; $display("FAIL parity_count: got %0d expected 2", q_dout.size());
    end else begin
      tests_run++;
      if (q_dout[0] !== 8'h07 || q_perr[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL parity_good: got %h perr %b expected 07 perr 0", q_dout[0], q_perr[0]);
      end
      tests_run++;
      if (q_dout[1] !== 8'h07 || q_perr[1] !== 1'b1) begin
        tests_failed++;
        $display("FAIL parity_bad: got %h perr %b expected 07 perr 1", q_dout[1], q_perr[1]);
      end
    end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h81;
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    @(negedge clk) rx = d[4];
    repeat (32) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL midframe_busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    tests_run++;
    if (busy !== 1'b0 || dout !== 8'h00 || rx_done_tick !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_reset_outputs: got busy %b dout %h done %b ferr %b expected 0 00 0 0",
               busy, dout, rx_done_tick, frame_err);
    end
    @(negedge clk) reset = 1'b0;
    idle(12);
    tests_run++;
    if (q_dout.size() !== 0) begin
      tests_failed++; $display("FAIL midframe_no_done: got %0d expected 0", q_dout.size());
    end
    send_frame(d, 1'b1);
    idle(2);
    tests_run++;
    if (q_dout.size() !== 1) begin
      tests_failed++; $display("FAIL after_reset_count: got %0d expected 1", q_dout.size());
    end else begin
      tests_run++;
      if (q_dout[0] !== 8'h81 || q_ferr[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL after_reset_frame: got %h ferr %b expected 81 ferr 0", q_dout[0], q_ferr[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_back_to_back();
    test_false_start();
    test_bad_stop();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
